// File: rtl/conv_window_3x3_pkg.sv
// Shared types, sizes and FSM encodings for the 3x3 convolution window builder.
package conv_window_3x3_pkg;
  localparam int MAX_CG   = 64;
  localparam int LB_DEPTH = 8192;
  localparam int WORD_W   = 64;
  localparam int WIN_W    = 9 * WORD_W;
  localparam int LEN_W    = 20;

  typedef logic [11:0]      dim_t;
  typedef logic [7:0]       cg_t;
  typedef logic [LEN_W-1:0] len_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Word slot of tap (ky, kx) inside the flattened window.
  function automatic int win_idx(input int ky, input int kx);
    return 3 * ky + kx;
  endfunction
endpackage

// File: rtl/conv_window_3x3_if.sv
// Pixel-word input stream and window output stream; slave side is the window builder.
interface conv_window_3x3_if;
  import conv_window_3x3_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WIN_W-1:0]  m_window;
  cg_t               m_cg;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport slave  (input  s_data, s_valid, m_ready,
                  output s_ready, m_window, m_cg, m_last, m_valid);
  modport master (output s_data, s_valid, m_ready,
                  input  s_ready, m_window, m_cg, m_last, m_valid);
endinterface

// File: rtl/conv_window_3x3_col_tap_shift.sv
// Per-row column history: taps at 0, cg and 2*cg words behind the current word.
// Contents need no reset; windows are only emitted once two full columns have shifted in.
module conv_window_3x3_col_tap_shift
  import conv_window_3x3_pkg::*;
(
  input  logic              clk,
  input  logic              shift,
  input  cg_t               cg,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] tap0,
  output logic [WORD_W-1:0] tap1,
  output logic [WORD_W-1:0] tap2
);
  localparam int DEPTH = 2 * MAX_CG;
  localparam int IW    = $clog2(DEPTH);

  logic [WORD_W-1:0] sh [DEPTH];
  logic [IW-1:0]     i1, i2;

  // sh[k] holds the word accepted k+1 shifts ago.
  assign i1   = IW'(cg - 8'd1);
  assign i2   = IW'({cg, 1'b0} - 9'd1);
  assign tap0 = din;
  assign tap1 = sh[i1];
  assign tap2 = sh[i2];

  always_ff @(posedge clk) begin
    if (shift) begin
      sh[0] <= din;
      for (int i = 1; i < DEPTH; i++) sh[i] <= sh[i-1];
    end
  end
endmodule

// File: rtl/conv_window_3x3_line_delay.sv
// Programmable-length word delay line: dout is the word written len pushes ago.
// Read is combinational from the slot about to be overwritten; clr rewinds the pointer.
module conv_window_3x3_line_delay #(
  parameter int DW    = 64,
  parameter int DEPTH = 8192,
  parameter int LW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          data_valid,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) ptr <= '0;
    else if (data_valid) ptr <= (LW'(ptr) == len - 1'b1) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (data_valid) mem[ptr] <= din;
  end
endmodule

// File: rtl/conv_window_3x3.sv
// Builds 3x3 windows from a raster stream of 64-bit channel-group words; window 1 cycle after accept.
// Input stalls while the output register holds an unaccepted window; full throughput otherwise.
module conv_window_3x3
  import conv_window_3x3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  dim_t cfg_width,
  input  dim_t cfg_height,
  input  cg_t  cfg_ch_groups,
  input  logic cfg_start,
  output logic cfg_err,
  output logic busy,
  output logic done,
  conv_window_3x3_if.slave io
);
  logic [1:0]        state;
  dim_t              width_q, height_q, col_cnt, row_cnt;
  cg_t               cg_q, cg_cnt;
  len_t              len_q, cfg_prod;
  logic              accept, last_word, emit, cfg_bad, priming;
  logic [WORD_W-1:0] r1, r2;
  logic [WORD_W-1:0] row_in [3];
  logic [WORD_W-1:0] tap [3][3];
  logic [WIN_W-1:0]  win;

  assign cfg_prod = len_t'(cfg_width) * len_t'(cfg_ch_groups);
  assign cfg_bad  = (cfg_width < 12'd3) || (cfg_height < 12'd3) || (cfg_ch_groups == 8'd0) ||
                    (cfg_ch_groups > 8'(MAX_CG)) || (cfg_prod > len_t'(LB_DEPTH));

  assign priming    = (state == ST_PRIME);
  assign io.s_ready = (state == ST_RUN) && (!io.m_valid || io.m_ready);
  assign accept     = io.s_valid && io.s_ready;
  assign last_word  = (cg_cnt == cg_q - 8'd1) && (col_cnt == width_q - 12'd1) &&
                      (row_cnt == height_q - 12'd1);
  assign emit       = accept && (row_cnt >= 12'd2) && (col_cnt >= 12'd2);

  conv_window_3x3_line_delay #(.DW(WORD_W), .DEPTH(LB_DEPTH), .LW(LEN_W)) u_ld1 (
    .clk(clk), .rst(rst), .clr(priming), .data_valid(accept), .len(len_q),
    .din(io.s_data), .dout(r1));

  conv_window_3x3_line_delay #(.DW(WORD_W), .DEPTH(LB_DEPTH), .LW(LEN_W)) u_ld2 (
    .clk(clk), .rst(rst), .clr(priming), .data_valid(accept), .len(len_q),
    .din(r1), .dout(r2));

  // ky=0 is the oldest row, kx=0 the oldest (leftmost) column.
  assign row_in[0] = r2;
  assign row_in[1] = r1;
  assign row_in[2] = io.s_data;

  for (genvar ky = 0; ky < 3; ky++) begin : g_row
    conv_window_3x3_col_tap_shift u_cts (
      .clk(clk), .shift(accept), .cg(cg_q), .din(row_in[ky]),
      .tap0(tap[ky][2]), .tap1(tap[ky][1]), .tap2(tap[ky][0]));
  end

  always_comb begin
    win = '0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        win[win_idx(ky, kx)*WORD_W +: WORD_W] = tap[ky][kx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      cg_q        <= '0;
      len_q       <= '0;
      cg_cnt      <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      cfg_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      io.m_valid  <= 1'b0;
      io.m_window <= '0;
      io.m_cg     <= '0;
      io.m_last   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              width_q  <= cfg_width;
              height_q <= cfg_height;
              cg_q     <= cfg_ch_groups;
              cg_cnt   <= '0;
              col_cnt  <= '0;
              row_cnt  <= '0;
              busy     <= 1'b1;
              state    <= ST_PRIME;
            end
          end
        end
        ST_PRIME: begin
          len_q <= len_t'(width_q) * len_t'(cg_q);
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            if (cg_cnt == cg_q - 8'd1) begin
              cg_cnt <= '0;
              if (col_cnt == width_q - 12'd1) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == height_q - 12'd1) ? '0 : row_cnt + 12'd1;
              end else begin
                col_cnt <= col_cnt + 12'd1;
              end
            end else begin
              cg_cnt <= cg_cnt + 8'd1;
            end
            if (last_word) state <= ST_DRAIN;
          end
        end
        default: begin
          if (!io.m_valid || io.m_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase

      if (emit) begin
        io.m_valid  <= 1'b1;
        io.m_window <= win;
        io.m_cg     <= cg_cnt;
        io.m_last   <= last_word;
      end else if (io.m_ready) begin
        io.m_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3: pixel words encode (cg<<24 | row<<8 | col) so every tap is predictable.
module tb_conv_window_3x3;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_width, cfg_height;
  logic [7:0]  cfg_ch_groups;
  logic        cfg_start;
  logic        cfg_err, busy, done;
  int          checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;

  conv_window_3x3_if bus();

  conv_window_3x3 dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_ch_groups(cfg_ch_groups), .cfg_start(cfg_start), .cfg_err(cfg_err),
    .busy(busy), .done(done), .io(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cfg_err) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int r, input int c, input int g);
    return (64'(g) << 24) | (64'(r) << 8) | 64'(c);
  endfunction

  function automatic logic [575:0] exp_win(input int r, input int c, input int g);
    logic [575:0] e;
    e = '0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        e[(3*ky+kx)*64 +: 64] = word(r - 2 + ky, c - 2 + kx, g);
    return e;
  endfunction

  task automatic start_cfg(input int w, input int h, input int cg);
    @(posedge clk); #1;
    cfg_width = 12'(w); cfg_height = 12'(h); cfg_ch_groups = 8'(cg); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic drive(input int w, input int h, input int cg, input bit rnd, input int limit);
    int  k;
    int  cyc;
    bit  acc;
    k = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int g = 0; g < cg; g++) begin
          if (k >= limit) begin
            bus.s_valid = 1'b0;
            return;
          end
          if (rnd)
            while ($urandom_range(0, 1) == 0) begin
              bus.s_valid = 1'b0;
              @(posedge clk); #1;
            end
          bus.s_valid = 1'b1;
          bus.s_data  = word(r, c, g);
          cyc = 0;
          do begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
            cyc++;
          end while (!acc && cyc < 200);
          if (!acc) begin
            check("drive_timeout", 0, 1);
            bus.s_valid = 1'b0;
            return;
          end
          k++;
        end
    bus.s_valid = 1'b0;
  endtask

  task automatic collect(input int w, input int h, input int cg, input bit rnd,
                         output logic [575:0] first);
    int           n, cyc, total, per;
    bit           held;
    logic [575:0] hold_win;
    n = 0; cyc = 0; held = 0; hold_win = '0; first = '0;
    total = (w - 2) * (h - 2) * cg;
    per   = (w - 2) * cg;
    while (n < total && cyc < 3000) begin
      @(posedge clk); #1;
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (held) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_window", bus.m_window, hold_win);
      end
      held = 0;
      if (bus.m_valid) begin
        if (bus.m_ready) begin
          int r, c, g;
          r = n / per + 2;
          c = (n % per) / cg + 2;
          g = n % cg;
          check("window", bus.m_window, exp_win(r, c, g));
          check("m_cg", bus.m_cg, g);
          check("m_last", bus.m_last, n == total - 1);
          if (n == 0) first = bus.m_window;
          n++;
        end else begin
          held = 1;
          hold_win = bus.m_window;
        end
      end
    end
    if (n < total) check("window_count", n, total);
  endtask

  task automatic run_frame(input int w, input int h, input int cg, input bit rnd,
                           input bit inject, output logic [575:0] first);
    int d0, e0;
    start_cfg(w, h, cg);
    d0 = done_cnt;
    e0 = err_cnt;
    check("busy_set", busy, 1);
    fork
      drive(w, h, cg, rnd, 1 << 30);
      collect(w, h, cg, rnd, first);
      begin
        if (inject) begin
          repeat (6) @(posedge clk);
          #1;
          cfg_width = 12'd2; cfg_ch_groups = 8'd0; cfg_start = 1'b1;
          @(posedge clk); #1;
          cfg_start = 1'b0;
        end
      end
    join
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_clear", busy, 0);
    check("m_valid_clear", bus.m_valid, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    check("done_count", done_cnt - d0, 1);
    check("no_cfg_err", err_cnt - e0, 0);
  endtask

  task automatic bad_cfg(input int w, input int h, input int cg, input string tag);
    start_cfg(w, h, cg);
    check({tag, "_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, cfg_err, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  logic [575:0] first;
  int           d_abort;

  initial begin
    rst = 1'b1; cfg_start = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_ch_groups = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_m_window", bus.m_window, 0);
    check("rst_m_cg", bus.m_cg, 0);
    check("rst_m_last", bus.m_last, 0);

    // 5x4, one channel group: first window is rows 0..2, cols 0..2.
    run_frame(5, 4, 1, 0, 0, first);
    check("first_w0", first[0 +: 64], 64'h000);
    check("first_w4", first[256 +: 64], 64'h101);
    check("first_w8", first[512 +: 64], 64'h202);

    run_frame(4, 3, 3, 0, 0, first);
    check("cg3_first_w2", first[128 +: 64], 64'h002);
    check("cg3_first_w6", first[384 +: 64], 64'h200);

    run_frame(5, 4, 1, 1, 0, first);
    run_frame(4, 3, 3, 1, 0, first);
    run_frame(6, 5, 2, 1, 0, first);

    bad_cfg(2, 4, 1, "narrow");
    bad_cfg(2731, 3, 3, "lb_overflow");
    bad_cfg(5, 4, 65, "cg_too_big");
    bad_cfg(5, 2, 1, "short");

    // Abort in row 2, then a clean frame must come out intact.
    d_abort = done_cnt;
    start_cfg(5, 4, 1);
    drive(5, 4, 1, 0, 12);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_s_ready", bus.s_ready, 0);
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_no_done", done_cnt - d_abort, 0);
    run_frame(5, 4, 1, 0, 0, first);
    check("abort_first_w4", first[256 +: 64], 64'h101);

    // cfg_start while running is ignored and the frame completes normally.
    run_frame(5, 4, 1, 1, 1, first);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
